// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings, controller state type and byte-lane mask helper
// for the SRAM controller and its array.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // 2^size contiguous lanes starting at lane 'off'; only meaningful for size <= 3.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [3:0] nbytes;
    logic [8:0] ones;
    nbytes = 4'd1 << size;
    ones   = (9'd1 << nbytes) - 9'd1;
    return ones[7:0] << off;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enable SRAM with registered (read-before-write) read port.
// With AHB_SRAM_PARITY_EN defined, one even-parity bit per byte is stored and checked.
module ahb_sram_array #(
  parameter  int DEPTH = 16384,
  parameter  int NB    = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   widx_i,
  input  logic [NB-1:0]   wmask_i,
  input  logic [8*NB-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   ridx_i,
  output logic [8*NB-1:0] rdata_o,
  output logic [NB-1:0]   rpar_err_o
);

  logic [8*NB-1:0] mem_q [DEPTH];
  logic [8*NB-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[ridx_i];
  end

  assign rdata_o = rdata_q;

`ifdef AHB_SRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rpar_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask_i[b]) par_q[widx_i][b] <= ^wdata_i[8*b +: 8];
      end
    end
    if (re_i) rpar_q <= par_q[ridx_i];
  end

  always_comb begin
    rpar_err_o = '0;
    for (int b = 0; b < NB; b++) rpar_err_o[b] = (^rdata_q[8*b +: 8]) ^ rpar_q[b];
  end
`else
  assign rpar_err_o = '0;
`endif

endmodule

// File: rtl/ahb_lite_sram_ctrl.sv
// AHB-Lite SRAM slave: transfer checks, wait/error FSM, write-to-read forwarding.
// Parity checking is enabled by defining AHB_SRAM_PARITY_EN.
module ahb_lite_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 65536,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_q, rd_q;
  logic [IDXW-1:0]       idx_q;
  logic [NB-1:0]         mask_q, fwd_mask_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  logic                  acc, chk_err, acc_ok, ready, resp, par_hit, we, re, fwd_hit;
  logic [31:0]           addr_ext;
  logic [7:0]            lm;
  logic [NB-1:0]         mask_a, par_err;
  logic [IDXW-1:0]       idx_a;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign addr_ext = 32'(HADDR);
  assign acc      = HSEL & HREADY & HTRANS[1];
  assign chk_err  = (HSIZE > 3'(OFFW))
                  | (|(addr_ext & ((32'd1 << HSIZE) - 32'd1)))
                  | (addr_ext >= 32'(MEM_BYTES));
  assign acc_ok   = acc & ~chk_err;
  assign lm       = lane_mask(HSIZE, 3'(HADDR[OFFW-1:0]));
  assign mask_a   = lm[NB-1:0];
  assign idx_a    = IDXW'(HADDR >> OFFW);

  assign we      = (state_q == ST_DONE) & wr_q & ~HRESET;
  assign re      = ready & acc_ok & ~HWRITE & ~HRESET;
  assign fwd_hit = we & (idx_a == idx_q);
  // Forwarded lanes carry fresh bus data, so their stale stored parity is ignored.
  assign par_hit = (state_q == ST_DONE) & rd_q & (|(par_err & mask_q & ~fwd_mask_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    unique case (state_q)
      ST_WAIT: begin
        ready = 1'b0;
        if (cnt_q == 3'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state_q == ST_ERR2) resp = HRESP_ERROR;
        if (par_hit) begin
          // A parity-failing DONE cycle is the first error cycle.
          ready   = 1'b0;
          resp    = HRESP_ERROR;
          state_d = ST_ERR2;
        end else if (acc) begin
          if (chk_err)               state_d = ST_ERR1;
          else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else                   state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      mask_q     <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ready) begin
        wr_q <= acc_ok & HWRITE;
        rd_q <= acc_ok & ~HWRITE;
        if (acc_ok) begin
          idx_q  <= idx_a;
          mask_q <= mask_a;
        end
        if (re) begin
          fwd_mask_q <= fwd_hit ? mask_q : '0;
          fwd_data_q <= HWDATA;
        end
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      for (int b = 0; b < NB; b++) begin
        HRDATA[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : arr_rdata[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = ready;
  assign HRESP     = resp;

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .NB    (NB)
  ) u_array (
    .clk_i      (HCLK),
    .we_i       (we),
    .widx_i     (idx_q),
    .wmask_i    (mask_q),
    .wdata_i    (HWDATA),
    .re_i       (re),
    .ridx_i     (idx_a),
    .rdata_o    (arr_rdata),
    .rpar_err_o (par_err)
  );

endmodule

// File: tb/tb_ahb_lite_sram_ctrl.sv
// Randomised bench for ahb_lite_sram_ctrl: a 32-bit zero-wait instance and a
// 64-bit, 4 KiB, 3-wait-state instance checked against a byte-addressed memory model.
module tb_ahb_lite_sram_ctrl;

  localparam int WS1 = 3;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    bit          par;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hsel0, hsel1;
  logic [31:0] hrdata0;
  logic [63:0] hrdata1;
  logic        hro0, hro1, hresp0, hresp1;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last_rd;
  logic [7:0]  mdl [2][4096];
  txn_t        q[$];

  always #5 clk = ~clk;

  ahb_lite_sram_ctrl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_BYTES(65536), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata[31:0]),
    .HREADY(hro0), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
  );

  ahb_lite_sram_ctrl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .MEM_BYTES(4096), .WAIT_STATES(WS1)
  ) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hro1), .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nb_of(input int d);   return (d != 0) ? 8 : 4;         endfunction
  function automatic int mem_of(input int d);  return (d != 0) ? 4096 : 65536;  endfunction
  function automatic int ws_of(input int d);   return (d != 0) ? WS1 : 0;       endfunction
  function automatic logic get_rdy(input int d);  return (d != 0) ? hro1 : hro0;     endfunction
  function automatic logic get_resp(input int d); return (d != 0) ? hresp1 : hresp0; endfunction
  function automatic logic [63:0] get_rdata(input int d);
    return (d != 0) ? hrdata1 : {32'h0, hrdata0};
  endfunction

  function automatic bit is_err(input int d, input txn_t t);
    int n = 1 << t.size;
    return (n > nb_of(d)) || ((int'(t.addr) % n) != 0) || (int'(t.addr) >= mem_of(d));
  endfunction

  function automatic logic [63:0] exp_word(input int d, input int addr);
    int base = addr - (addr % nb_of(d));
    logic [63:0] w = '0;
    for (int k = 0; k < nb_of(d); k++) w[8*k +: 8] = mdl[d][base + k];
    return w;
  endfunction

  function automatic txn_t mk(input bit wr, input int addr, input int size, input logic [63:0] wd);
    txn_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.wr = wr; t.addr = 16'(addr);
    t.size = 3'(size); t.wdata = wd; t.par = 1'b0;
    return t;
  endfunction

  task automatic drive_addr(input int d, input txn_t t);
    hsel0  = (d == 0) && t.sel;
    hsel1  = (d != 0) && t.sel;
    htrans = t.trans;
    hwrite = t.wr;
    haddr  = t.addr;
    hsize  = t.size;
    hburst = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic complete(input int d, input txn_t t, input int lat, input bit wresp);
    bit act = t.sel && t.trans[1];
    bit err = act && (is_err(d, t) || t.par);
    int exp_lat = !act ? 0 : t.par ? ws_of(d) + 1 : err ? 1 : ws_of(d);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("hresp", 64'(get_resp(d)), 64'(err));
    chk("wait_resp", 64'(wresp), 64'(err));
    if ((act && !err && !t.wr) || t.par) begin
      last_rd = get_rdata(d);
      chk("rdata", get_rdata(d), exp_word(d, int'(t.addr)));
    end else begin
      chk("rdata_zero", get_rdata(d), 64'h0);
    end
    if (act && !err && t.wr) begin
      for (int i = 0; i < (1 << t.size); i++) begin
        int a = int'(t.addr) + i;
        mdl[d][a] = t.wdata[8*(a % nb_of(d)) +: 8];
      end
    end
  endtask

  // Pipelined master: called and returns #1 after a rising edge; HREADY = HREADYOUT.
  task automatic run(input int d);
    txn_t cur;
    bit   have_cur = 1'b0;
    int   lat = 0;
    bit   wresp = 1'b0;
    int   guard = 0;
    logic rdy;
    while (1) begin
      if (have_cur) hwdata = cur.wdata;
      rdy = get_rdy(d);
      if (have_cur) begin
        if (rdy) complete(d, cur, lat, wresp);
        else begin
          lat++;
          wresp = wresp | get_resp(d);
        end
      end
      if (rdy) begin
        have_cur = 1'b0;
        if (q.size() == 0) begin
          drive_idle();
          break;
        end
        cur = q.pop_front();
        drive_addr(d, cur);
        have_cur = 1'b1; lat = 0; wresp = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        chk("timeout_outstanding", 64'(q.size() + int'(have_cur)), 64'h0);
        q.delete();
        drive_idle();
        break;
      end
    end
  endtask

  task automatic gen_init(input int d, input int words);
    for (int w = 0; w < words; w++)
      q.push_back(mk(1'b1, w * nb_of(d), $clog2(nb_of(d)), {$urandom, $urandom}));
  endtask

  task automatic gen_rand(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      t.sel   = ($urandom_range(0, 19) != 0);
      t.trans = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      t.wr    = $urandom_range(0, 1) == 1;
      t.size  = 3'($urandom_range(0, (d != 0) ? 4 : 3));
      if (d != 0 && $urandom_range(0, 9) == 0) t.addr = 16'($urandom_range(4096, 65535));
      else t.addr = 16'($urandom_range(0, (d != 0) ? 511 : 255));
      if ($urandom_range(0, 9) < 8) t.addr = t.addr & ~16'((1 << t.size) - 1);
      t.wdata = {$urandom, $urandom};
      t.par   = 1'b0;
      q.push_back(t);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int a = 0; a < 4096; a++) mdl[d][a] = 8'h00;
    rst = 1'b1; hwdata = '0; haddr = '0; hsize = '0; hburst = '0; last_rd = '0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout0", 64'(hro0), 64'h1);
    chk("rst_hresp0", 64'(hresp0), 64'h0);
    chk("rst_hrdata0", 64'(hrdata0), 64'h0);
    chk("rst_hreadyout1", 64'(hro1), 64'h1);
    chk("rst_hresp1", 64'(hresp1), 64'h0);
    chk("rst_hrdata1", hrdata1, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit, zero wait states
    gen_init(0, 64);
    run(0);
    q.push_back(mk(1'b1, 'h10, 2, 64'hDEADBEEF));
    q.push_back(mk(1'b0, 'h10, 2, 64'h0));
    run(0);
    chk("fwd_deadbeef", last_rd, 64'hDEADBEEF);
    q.push_back(mk(1'b1, 'h10, 2, 64'h11223344));
    q.push_back(mk(1'b1, 'h13, 0, 64'hAA000000));
    q.push_back(mk(1'b0, 'h10, 2, 64'h0));
    run(0);
    chk("byte_merge", last_rd, 64'hAA223344);
    q.push_back(mk(1'b0, 'h01, 1, 64'h0));
    q.push_back(mk(1'b1, 'h01, 1, 64'hFFFFFFFF));
    q.push_back(mk(1'b0, 'h08, 3, 64'h0));
    q.push_back(mk(1'b0, 'h00, 2, 64'h0));
    run(0);
    gen_rand(0, 300);
    run(0);

    // 64-bit, 4 KiB, 3 wait states
    gen_init(1, 64);
    run(1);
    q.push_back(mk(1'b0, 'h1000, 3, 64'h0));
    q.push_back(mk(1'b1, 'hFF8, 3, 64'h0123456789ABCDEF));
    q.push_back(mk(1'b0, 'hFF8, 3, 64'h0));
    run(1);
    chk("dword_readback", last_rd, 64'h0123456789ABCDEF);
    q.push_back(mk(1'b0, 'h20, 2, 64'h0));
    q.push_back(mk(1'b0, 'h24, 4, 64'h0));
    run(1);
    gen_rand(1, 200);
    run(1);

    // reset during the WAIT of a write to 0x40
    q.push_back(mk(1'b1, 'h40, 3, 64'h5A5A_1234_C3C3_8765));
    run(1);
    drive_addr(1, mk(1'b1, 'h40, 3, 64'h0));
    @(posedge clk); #1;
    drive_idle();
    hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("wr_wait_hreadyout", 64'(hro1), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_hreadyout", 64'(hro1), 64'h1);
    chk("midrst_hresp", 64'(hresp1), 64'h0);
    chk("midrst_hrdata", hrdata1, 64'h0);
    q.push_back(mk(1'b0, 'h40, 3, 64'h0));
    run(1);
    chk("midrst_keep", last_rd, 64'h5A5A_1234_C3C3_8765);

`ifdef AHB_SRAM_PARITY_EN
    begin
      txn_t t;
      u_dut1.u_array.par_q[8][0] = ~u_dut1.u_array.par_q[8][0];
      t = mk(1'b0, 'h40, 3, 64'h0);
      t.par = 1'b1;
      q.push_back(t);
      run(1);
    end
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
